int_simd_alu: RTL and testbench

- Memory-mapped, parametrised integer ALU on the execution-engine bus.
- Holds LANES independent DATA_W-bit lanes with two source registers and a result register.
- Executes one opcode across all lanes per start command.
- Adds a multi-cycle divider, busy/done handshake and status word; sits beside the execution engine, selected by address[15:12] == UNIT_ID.

---
 rtl/int_simd_alu.sv | 235 +++++++++++++++++++++++
 tb/tb_int_simd_alu.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_simd_alu.sv
// int_simd_alu
// Memory-mapped integer SIMD ALU on the execution-engine bus. It holds LANES
// independent unsigned DATA_W-bit lanes and runs one opcode across every lane
// for each start command. ADD/SUB/MUL/AND/OR/XOR take one cycle. DIV/REM use a
// restoring divider that produces one quotient bit per lane per cycle.
//
// Ports
//   Clk         rising-edge clock
//   nReset      asynchronous active-low reset
//   address     [15:12] unit select, [7:4] opcode, [3:0] register/command
//   nRead       active-low read strobe
//   nWrite      active-low write strobe
//   ExeDataOut  write data; lane i = [i*DATA_W +: DATA_W]
//   IntDataOut  registered read data (result or status)
//   Busy        operation in progress
//   Done        result valid since the last accepted start
//
// Register offsets (address[3:0])
//   0 src1 (W), 1 src2 (W), 2 result (R), 3 start (W, opcode in [7:4]),
//   4 status (R) = {dz at [8 +: LANES], ovr[3], err[2], Done[1], Busy[0]}
module int_simd_alu #(
    parameter int         DATA_W  = 16,
    parameter int         LANES   = 4,
    parameter int         BUS_W   = 256,
    parameter logic [3:0] UNIT_ID = 4'h3
) (
    input  logic             Clk,
    input  logic             nReset,
    input  logic [15:0]      address,
    input  logic             nRead,
    input  logic             nWrite,
    input  logic [BUS_W-1:0] ExeDataOut,
    output logic [BUS_W-1:0] IntDataOut,
    output logic             Busy,
    output logic             Done
);

    localparam int VW    = LANES * DATA_W;
    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [3:0] REG_SRC1   = 4'd0;
    localparam logic [3:0] REG_SRC2   = 4'd1;
    localparam logic [3:0] REG_RESULT = 4'd2;
    localparam logic [3:0] REG_START  = 4'd3;
    localparam logic [3:0] REG_STATUS = 4'd4;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_REM = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DIV, S_DONE} state_t;

    state_t             state;
    logic [VW-1:0]      src1, src2, result;
    logic [3:0]         op_q;
    logic [CNT_W-1:0]   cnt;
    logic               err, ovr;
    logic [LANES-1:0]   dz;

    // Per-lane divider working registers
    logic [DATA_W-1:0]  div_rem [LANES];
    logic [DATA_W-1:0]  div_quo [LANES];
    logic [DATA_W-1:0]  div_den [LANES];
    logic [DATA_W-1:0]  rem_nx  [LANES];
    logic [DATA_W-1:0]  quo_nx  [LANES];
    logic [DATA_W:0]    shifted;

    logic [VW-1:0]      alu_vec, div_vec;
    logic [BUS_W-1:0]   status_w;

    logic               sel, wr_en, rd_en, busy_hit, cmd_is_div;
    logic [3:0]         reg_off, cmd_op;
    logic               unused_bits;

    assign sel        = (address[15:12] == UNIT_ID);
    assign wr_en      = sel && !nWrite && nRead;
    assign rd_en      = sel && !nRead && nWrite;
    assign reg_off    = address[3:0];
    assign cmd_op     = address[7:4];
    assign cmd_is_div = (cmd_op == OP_DIV) || (cmd_op == OP_REM);
    // Any write that would disturb a running operation flags an overrun
    assign busy_hit   = wr_en && ((reg_off == REG_SRC1) || (reg_off == REG_SRC2) ||
                                  (reg_off == REG_START));
    assign unused_bits = &{1'b0, address[11:8], ExeDataOut};

    function automatic logic [DATA_W-1:0] lane_alu(input logic [3:0]        op,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic [2*DATA_W-1:0] prod;
        prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        case (op)
            OP_ADD:  lane_alu = a + b;
            OP_SUB:  lane_alu = a - b;
            OP_MUL:  lane_alu = prod[DATA_W-1:0];
            OP_AND:  lane_alu = a & b;
            OP_OR:   lane_alu = a | b;
            OP_XOR:  lane_alu = a ^ b;
            default: lane_alu = '0;
        endcase
    endfunction

    // One restoring step per lane. A zero divisor always "fits", so the
    // quotient fills with ones and the remainder ends as the dividend.
    always_comb begin
        rem_nx  = '{default: '0};
        quo_nx  = '{default: '0};
        shifted = '0;
        for (int i = 0; i < LANES; i++) begin
            shifted = {div_rem[i], div_quo[i][DATA_W-1]};
            if (shifted >= {1'b0, div_den[i]}) begin
                shifted   = shifted - {1'b0, div_den[i]};
                quo_nx[i] = {div_quo[i][DATA_W-2:0], 1'b1};
            end else begin
                quo_nx[i] = {div_quo[i][DATA_W-2:0], 1'b0};
            end
            rem_nx[i] = shifted[DATA_W-1:0];
        end
    end

    always_comb begin
        alu_vec = '0;
        div_vec = '0;
        for (int i = 0; i < LANES; i++) begin
            alu_vec[i*DATA_W +: DATA_W] = lane_alu(op_q, src1[i*DATA_W +: DATA_W],
                                                   src2[i*DATA_W +: DATA_W]);
            div_vec[i*DATA_W +: DATA_W] = (op_q == OP_REM) ? rem_nx[i] : quo_nx[i];
        end
    end

    always_comb begin
        status_w            = '0;
        status_w[8 +: LANES] = dz;
        status_w[3]         = ovr;
        status_w[2]         = err;
        status_w[1]         = Done;
        status_w[0]         = Busy;
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state      <= S_IDLE;
            src1       <= '0;
            src2       <= '0;
            result     <= '0;
            op_q       <= '0;
            cnt        <= '0;
            err        <= 1'b0;
            ovr        <= 1'b0;
            dz         <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            IntDataOut <= '0;
            for (int i = 0; i < LANES; i++) begin
                div_rem[i] <= '0;
                div_quo[i] <= '0;
                div_den[i] <= '0;
            end
        end else begin
            // Result reads always see the last completed result
            if (rd_en) begin
                if (reg_off == REG_RESULT)
                    IntDataOut <= BUS_W'(result);
                else if (reg_off == REG_STATUS)
                    IntDataOut <= status_w;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (wr_en) begin
                        case (reg_off)
                            REG_SRC1: src1 <= ExeDataOut[VW-1:0];
                            REG_SRC2: src2 <= ExeDataOut[VW-1:0];
                            REG_START: begin
                                if (cmd_op[3]) begin
                                    err <= 1'b1;
                                end else begin
                                    op_q <= cmd_op;
                                    Done <= 1'b0;
                                    Busy <= 1'b1;
                                    err  <= 1'b0;
                                    ovr  <= 1'b0;
                                    if (cmd_is_div) begin
                                        state <= S_DIV;
                                        cnt   <= '0;
                                        for (int i = 0; i < LANES; i++) begin
                                            div_rem[i] <= '0;
                                            div_quo[i] <= src1[i*DATA_W +: DATA_W];
                                            div_den[i] <= src2[i*DATA_W +: DATA_W];
                                            dz[i]      <= (src2[i*DATA_W +: DATA_W] == '0);
                                        end
                                    end else begin
                                        state <= S_EXEC;
                                        dz    <= '0;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_EXEC: begin
                    result <= alu_vec;
                    Busy   <= 1'b0;
                    Done   <= 1'b1;
                    state  <= S_DONE;
                    if (busy_hit)
                        ovr <= 1'b1;
                end
                S_DIV: begin
                    for (int i = 0; i < LANES; i++) begin
                        div_rem[i] <= rem_nx[i];
                        div_quo[i] <= quo_nx[i];
                    end
                    cnt <= cnt + CNT_W'(1);
                    // Last quotient bit lands on the DATA_W-th edge after start
                    if (cnt == CNT_W'(DATA_W - 1)) begin
                        result <= div_vec;
                        Busy   <= 1'b0;
                        Done   <= 1'b1;
                        state  <= S_DONE;
                    end
                    if (busy_hit)
                        ovr <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_int_simd_alu.sv
// Testbench for int_simd_alu: table-driven lane vectors with a result
// scoreboard, plus hand-written reset, busy-protection and illegal-access
// sequences.
module tb_int_simd_alu;

    localparam int         DATA_W  = 16;
    localparam int         LANES   = 4;
    localparam int         BUS_W   = 256;
    localparam logic [3:0] UNIT_ID = 4'h3;

    logic             Clk;
    logic             nReset;
    logic [15:0]      address;
    logic             nRead;
    logic             nWrite;
    logic [BUS_W-1:0] ExeDataOut;
    logic [BUS_W-1:0] IntDataOut;
    logic             Busy;
    logic             Done;

    int_simd_alu #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .BUS_W  (BUS_W),
        .UNIT_ID(UNIT_ID)
    ) dut (
        .Clk       (Clk),
        .nReset    (nReset),
        .address   (address),
        .nRead     (nRead),
        .nWrite    (nWrite),
        .ExeDataOut(ExeDataOut),
        .IntDataOut(IntDataOut),
        .Busy      (Busy),
        .Done      (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] s1;
        logic [63:0] s2;
        logic [63:0] ex;
        int          lat;
        logic [3:0]  dz;
    } vec_t;

    vec_t             tbl [8];
    logic [BUS_W-1:0] exp_q [$];
    logic [BUS_W-1:0] last_out;
    int               n_cmp = 0;
    int               n_err = 0;

    function automatic logic [63:0] v4(input logic [15:0] a, input logic [15:0] b,
                                       input logic [15:0] c, input logic [15:0] d);
        return {d, c, b, a};
    endfunction

    function automatic logic [15:0] model(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
        logic [31:0] p;
        p = {16'h0, a} * {16'h0, b};
        case (op)
            4'd0:    return 16'(a + b);
            4'd1:    return 16'(a - b);
            4'd2:    return p[15:0];
            4'd3:    return (b == 16'h0) ? 16'hFFFF : 16'(a / b);
            4'd4:    return (b == 16'h0) ? a : 16'(a % b);
            4'd5:    return a & b;
            4'd6:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    task automatic check(input string name, input logic [BUS_W-1:0] act,
                         input logic [BUS_W-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic bus_cycle(input logic [3:0] off, input logic [3:0] op, input logic rd,
                             input logic wr, input logic [BUS_W-1:0] d);
        @(negedge Clk);
        address    = {UNIT_ID, 4'h0, op, off};
        nRead      = !rd;
        nWrite     = !wr;
        ExeDataOut = d;
        @(posedge Clk);
        #1;
        nRead  = 1'b1;
        nWrite = 1'b1;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (Busy && cyc < 100) begin
            cyc++;
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic read_result(input string name);
        logic [BUS_W-1:0] e;
        bus_cycle(4'd2, 4'd0, 1'b1, 1'b0, '0);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got %h", name, IntDataOut);
        end else begin
            e = exp_q.pop_front();
            check({name, " result"}, IntDataOut, e);
        end
    endtask

    task automatic read_status(input string name, input logic [BUS_W-1:0] e);
        bus_cycle(4'd4, 4'd0, 1'b1, 1'b0, '0);
        check({name, " status"}, IntDataOut, e);
        last_out = e;
    endtask

    task automatic start_and_check(input string name, input logic [3:0] op,
                                   input logic [63:0] ex, input int lat,
                                   input logic [3:0] dzx);
        int cyc;
        bus_cycle(4'd3, op, 1'b0, 1'b1, '0);
        exp_q.push_back(BUS_W'(ex));
        check({name, " busy@t0"}, BUS_W'(Busy), BUS_W'(1));
        check({name, " done@t0"}, BUS_W'(Done), BUS_W'(0));
        wait_idle(cyc);
        check({name, " latency"}, BUS_W'(cyc), BUS_W'(lat));
        check({name, " done"}, BUS_W'(Done), BUS_W'(1));
        read_result(name);
        read_status(name, BUS_W'({dzx, 8'h02}));
    endtask

    task automatic run_vec(input string name, input vec_t v);
        bus_cycle(4'd0, 4'd0, 1'b0, 1'b1, BUS_W'(v.s1));
        bus_cycle(4'd1, 4'd0, 1'b0, 1'b1, BUS_W'(v.s2));
        start_and_check(name, v.op, v.ex, v.lat, v.dz);
    endtask

    initial begin
        vec_t        rv;
        logic [15:0] a, b;
        int          cyc;

        tbl[0] = '{4'd0, v4(16'hFFFF, 16'd5, 16'd100, 16'd0), v4(16'd1, 16'd7, 16'd50, 16'd0),
                   v4(16'h0000, 16'd12, 16'd150, 16'd0), 1, 4'b0000};
        tbl[1] = '{4'd1, v4(16'hFFFF, 16'd5, 16'd100, 16'd0), v4(16'd1, 16'd7, 16'd50, 16'd0),
                   v4(16'hFFFE, 16'hFFFE, 16'd50, 16'd0), 1, 4'b0000};
        tbl[2] = '{4'd2, v4(16'h0100, 16'd3, 16'hFFFF, 16'd2), v4(16'h0100, 16'd4, 16'd2, 16'd0),
                   v4(16'h0000, 16'd12, 16'hFFFE, 16'd0), 1, 4'b0000};
        tbl[3] = '{4'd3, v4(16'd100, 16'd7, 16'hFFFF, 16'd9), v4(16'd7, 16'd7, 16'd16, 16'd0),
                   v4(16'd14, 16'd1, 16'h0FFF, 16'hFFFF), 16, 4'b1000};
        tbl[4] = '{4'd4, v4(16'd100, 16'd7, 16'hFFFF, 16'd9), v4(16'd7, 16'd7, 16'd16, 16'd0),
                   v4(16'd2, 16'd0, 16'd15, 16'd9), 16, 4'b1000};
        tbl[5] = '{4'd5, v4(16'hF0F0, 16'h1234, 16'hFFFF, 16'h0000),
                   v4(16'h0FF0, 16'h00FF, 16'h8001, 16'hFFFF),
                   v4(16'h00F0, 16'h0034, 16'h8001, 16'h0000), 1, 4'b0000};
        tbl[6] = '{4'd6, v4(16'hF0F0, 16'h1234, 16'hFFFF, 16'h0000),
                   v4(16'h0FF0, 16'h00FF, 16'h8001, 16'hFFFF),
                   v4(16'hFFF0, 16'h12FF, 16'hFFFF, 16'hFFFF), 1, 4'b0000};
        tbl[7] = '{4'd7, v4(16'hF0F0, 16'h1234, 16'hFFFF, 16'h0000),
                   v4(16'h0FF0, 16'h00FF, 16'h8001, 16'hFFFF),
                   v4(16'hFF00, 16'h12CB, 16'h7FFE, 16'hFFFF), 1, 4'b0000};

        nReset     = 1'b0;
        nRead      = 1'b1;
        nWrite     = 1'b1;
        address    = '0;
        ExeDataOut = '0;
        repeat (3) @(posedge Clk);
        #1;
        check("reset out", IntDataOut, '0);
        check("reset busy", BUS_W'(Busy), BUS_W'(0));
        check("reset done", BUS_W'(Done), BUS_W'(0));
        @(negedge Clk);
        nReset = 1'b1;
        exp_q.push_back('0);
        read_result("post-reset");
        read_status("post-reset", '0);

        for (int i = 0; i < 8; i++)
            run_vec($sformatf("tbl%0d", i), tbl[i]);

        for (int k = 0; k < 6; k++) begin
            rv.op  = 4'($urandom_range(0, 7));
            rv.dz  = '0;
            rv.lat = (rv.op == 4'd3 || rv.op == 4'd4) ? 16 : 1;
            for (int l = 0; l < LANES; l++) begin
                a = 16'($urandom);
                b = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom >> $urandom_range(0, 15));
                rv.s1[l*16 +: 16] = a;
                rv.s2[l*16 +: 16] = b;
                rv.ex[l*16 +: 16] = model(rv.op, a, b);
                if (rv.lat == 16 && b == 16'h0)
                    rv.dz[l] = 1'b1;
            end
            run_vec($sformatf("rnd%0d", k), rv);
        end

        // Reset in the middle of a divide
        bus_cycle(4'd0, 4'd0, 1'b0, 1'b1, BUS_W'(tbl[3].s1));
        bus_cycle(4'd1, 4'd0, 1'b0, 1'b1, BUS_W'(tbl[3].s2));
        bus_cycle(4'd3, 4'd3, 1'b0, 1'b1, '0);
        repeat (3) begin
            @(posedge Clk);
            #1;
        end
        bus_cycle(4'd4, 4'd0, 1'b1, 1'b0, '0);
        check("midrst busy status", IntDataOut, BUS_W'(12'h801));
        #2 nReset = 1'b0;
        #1;
        check("midrst out", IntDataOut, '0);
        check("midrst busy", BUS_W'(Busy), BUS_W'(0));
        check("midrst done", BUS_W'(Done), BUS_W'(0));
        @(negedge Clk);
        nReset = 1'b1;
        exp_q.push_back('0);
        read_result("midrst");
        read_status("midrst", '0);

        // Writes and starts while busy are dropped and flag overrun
        bus_cycle(4'd0, 4'd0, 1'b0, 1'b1, BUS_W'(tbl[3].s1));
        bus_cycle(4'd1, 4'd0, 1'b0, 1'b1, BUS_W'(tbl[3].s2));
        bus_cycle(4'd3, 4'd3, 1'b0, 1'b1, '0);
        exp_q.push_back(BUS_W'(tbl[3].ex));
        bus_cycle(4'd0, 4'd0, 1'b0, 1'b1, {(BUS_W/16){16'hAAAA}});
        bus_cycle(4'd3, 4'd0, 1'b0, 1'b1, '0);
        check("prot busy", BUS_W'(Busy), BUS_W'(1));
        wait_idle(cyc);
        check("prot done", BUS_W'(Done), BUS_W'(1));
        read_result("prot");
        read_status("prot", BUS_W'(12'h80A));
        start_and_check("prot add", 4'd0, v4(16'd107, 16'd14, 16'h000F, 16'd9), 1, 4'b0000);

        // Illegal opcode and dual-strobe accesses
        bus_cycle(4'd3, 4'hC, 1'b0, 1'b1, '0);
        check("illegal busy", BUS_W'(Busy), BUS_W'(0));
        check("illegal done", BUS_W'(Done), BUS_W'(1));
        check("illegal out", IntDataOut, last_out);
        bus_cycle(4'd2, 4'd0, 1'b1, 1'b1, '0);
        check("dual rd out", IntDataOut, last_out);
        bus_cycle(4'd0, 4'd0, 1'b1, 1'b1, {(BUS_W/16){16'h5555}});
        check("dual wr busy", BUS_W'(Busy), BUS_W'(0));
        bus_cycle(4'd7, 4'd0, 1'b1, 1'b0, '0);
        check("other rd out", IntDataOut, last_out);
        read_status("illegal", BUS_W'(12'h006));
        start_and_check("reuse add", 4'd0, v4(16'd107, 16'd14, 16'h000F, 16'd9), 1, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
